contact_pack_writer: RTL and testbench
======================================

# contact_pack_writer

Upstream stage of the 7-input contact RAM. It accepts contact-result words one per cycle from the sphere-collision datapath over a valid/ready handshake and packs each group of 7 words into a single record. Each record is written as one parallel 7-word write strobe at an auto-incrementing base address. The block tracks RAM occupancy, raises a full flag, and stalls the producer until software or the controller clears the buffer.

## Interface
Parameters:
- DATA_WIDTH, 32, width of each contact word
- ADDR_WIDTH, 32, width of the RAM write address
- RAM_DEPTH, 32, number of words in the downstream RAM
- Record size is fixed at 7 words: pos x/y/z, normal x/y/z, depth, in that order.

Ports:
- clk  in  1  single clock, all state on posedge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  producer word valid
- in_data  in  DATA_WIDTH  contact word
- in_ready  out  1  block accepts a word this cycle
- clear  in  1  one-cycle pulse: empty the buffer (base and count return to 0)
- cs  out  1  RAM chip select, registered
- we  out  1  RAM write enable, registered
- addressin  out  ADDR_WIDTH  RAM base write address, registered
- datain0..datain6  out  DATA_WIDTH each  packed record words 0..6, registered
- fm  out  1  memory full
- contact_count  out  8  records written since the last reset or clear
- overflow  out  1  sticky: in_valid was seen while fm=1; cleared by rst or clear

## Operation
- Transfer rule: a word transfers on a posedge where in_valid && in_ready.
- States:
  - COLLECT: in_ready=1. Each transfer loads in_data into datain[idx], then idx++ (idx is 3 bits, 0..6). The transfer with idx==6 resets idx to 0 and moves to WRITE.
  - WRITE: lasts exactly 1 cycle. cs=we=1, addressin=base, in_ready=0. On exit, base+=7 and contact_count+=1. If new base+7 > RAM_DEPTH, go to FULL; otherwise go to COLLECT.
  - FULL: fm=1, in_ready=0, cs=we=0. The state holds until clear.
- Address arithmetic: base is computed at ADDR_WIDTH width and never wraps. With RAM_DEPTH=32, the valid bases are 0, 7, 14, 21, giving 4 records. The full check uses a comparison one bit wider, so it cannot overflow.
- datain0..6 hold their values after a write until they are overwritten by the next record.
- clear:
  - In COLLECT: discards the partial record (idx=0), base=0, count=0. clear takes priority over a simultaneous transfer, and that word is dropped.
  - In WRITE: the write still completes this cycle, then base=0, count=0, next state COLLECT, fm=0.
  - In FULL: next state COLLECT, base=0, count=0, fm=0, overflow=0.
- overflow: set in any cycle where state==FULL && in_valid && !clear.
- Reset (async, immediate): state=COLLECT, idx=0, base=0, cs=we=0, addressin=0, datain0..6=0, fm=0, contact_count=0, overflow=0.
- in_ready is a registered state decode. It must not depend combinationally on in_valid.

## Timing
- The 7th word is accepted at edge N. cs/we are high during cycle N to N+1, and the RAM samples the record at edge N+1.
- in_ready is 0 for exactly that one cycle. It returns to 1 after edge N+1 unless the block enters FULL.
- Throughput: 1 record per 8 cycles with in_valid held high.
- fm rises on the same edge on which WRITE exits into FULL, so it is visible in the cycle after the last write strobe.
- Asserting rst mid-record drops all collected words. No cs/we pulse occurs after rst asserts.
- The downstream RAM's oe/read port is not driven by this block.

## Test plan
- Single record: reset, then feed words 0x10..0x16 back-to-back. Required: one cycle with cs=we=1, addressin=0, datain0=0x10 … datain6=0x16; contact_count=1; fm=0.
- Fill (RAM_DEPTH=32): feed 28 words continuously. Required: write strobes at addressin 0, 7, 14, 21, each 8 cycles apart; contact_count=4; fm=1; in_ready=0.
- Overflow and recovery: after the fill, drive in_valid=1 for 3 cycles. Required: overflow=1, no cs/we. Then pulse clear. Required: fm=0, overflow=0, contact_count=0, and the next record is written at addressin=0.
- Partial discard: feed 4 words, pulse clear, then feed 7 words 0xA0..0xA6. Required: a single write at addressin=0 with datain0=0xA0.
- Bubbles: toggle in_valid every other cycle across 7 words. Required: the record is still packed in order, and a single write occurs 1 cycle after the 7th transfer.
- Async reset: assert rst mid-record, between clock edges. Required: all outputs are 0 immediately, and the next 7 words write at addressin=0.

Source files
------------

// File: rtl/contact_pack_writer.sv
// rtl/contact_pack_writer.sv - packs 7-word contact records into parallel RAM write strobes
module contact_pack_writer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int RAM_DEPTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    input  logic                  clear,
    output logic                  cs,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] addressin,
    output logic [DATA_WIDTH-1:0] datain0,
    output logic [DATA_WIDTH-1:0] datain1,
    output logic [DATA_WIDTH-1:0] datain2,
    output logic [DATA_WIDTH-1:0] datain3,
    output logic [DATA_WIDTH-1:0] datain4,
    output logic [DATA_WIDTH-1:0] datain5,
    output logic [DATA_WIDTH-1:0] datain6,
    output logic                  fm,
    output logic [7:0]            contact_count,
    output logic                  overflow
);

    typedef enum logic [1:0] {S_COLLECT, S_WRITE, S_FULL} state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [2:0]            r_idx;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH-1:0] r_addressin;
    logic [7:0]            r_count;
    logic                  r_overflow;
    logic [DATA_WIDTH-1:0] r_data [0:6];

    logic                  w_xfer;
    logic                  w_last_word;
    logic [ADDR_WIDTH-1:0] w_base_next;
    logic [ADDR_WIDTH:0]   w_next_end;
    logic                  w_no_room;

    assign w_xfer      = in_valid && (r_state == S_COLLECT);
    assign w_last_word = (r_idx == 3'd6);
    assign w_base_next = r_base + ADDR_WIDTH'(7);
    // One extra bit so the end-of-next-record check cannot wrap.
    assign w_next_end  = {1'b0, w_base_next} + (ADDR_WIDTH+1)'(7);
    assign w_no_room   = (w_next_end > (ADDR_WIDTH+1)'(RAM_DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_COLLECT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_COLLECT: begin
                if (!clear && w_xfer && w_last_word) begin
                    w_next_state = S_WRITE;
                end
            end
            S_WRITE: begin
                if (clear) begin
                    w_next_state = S_COLLECT;
                end else if (w_no_room) begin
                    w_next_state = S_FULL;
                end else begin
                    w_next_state = S_COLLECT;
                end
            end
            S_FULL: begin
                if (clear) begin
                    w_next_state = S_COLLECT;
                end
            end
            default: w_next_state = S_COLLECT;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        cs       = 1'b0;
        we       = 1'b0;
        fm       = 1'b0;
        case (r_state)
            S_COLLECT: in_ready = 1'b1;
            S_WRITE: begin
                cs = 1'b1;
                we = 1'b1;
            end
            S_FULL:  fm = 1'b1;
            default: in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx       <= 3'd0;
            r_base      <= '0;
            r_addressin <= '0;
            r_count     <= 8'd0;
            r_overflow  <= 1'b0;
            for (int i = 0; i < 7; i++) begin
                r_data[i] <= '0;
            end
        end else if (clear) begin
            // clear wins over a same-cycle transfer; the write in progress still completes.
            r_idx      <= 3'd0;
            r_base     <= '0;
            r_count    <= 8'd0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                S_COLLECT: begin
                    if (w_xfer) begin
                        for (int i = 0; i < 7; i++) begin
                            if (r_idx == 3'(i)) begin
                                r_data[i] <= in_data;
                            end
                        end
                        if (w_last_word) begin
                            r_idx       <= 3'd0;
                            r_addressin <= r_base;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end
                end
                S_WRITE: begin
                    r_base  <= w_base_next;
                    r_count <= r_count + 8'd1;
                end
                S_FULL: begin
                    if (in_valid) begin
                        r_overflow <= 1'b1;
                    end
                end
                default: r_idx <= 3'd0;
            endcase
        end
    end

    assign addressin     = r_addressin;
    assign contact_count = r_count;
    assign overflow      = r_overflow;
    assign datain0       = r_data[0];
    assign datain1       = r_data[1];
    assign datain2       = r_data[2];
    assign datain3       = r_data[3];
    assign datain4       = r_data[4];
    assign datain5       = r_data[5];
    assign datain6       = r_data[6];

endmodule

// File: tb/tb_contact_pack_writer.sv
// tb/tb_contact_pack_writer.sv - self-checking bench for contact_pack_writer
module tb_contact_pack_writer;

    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        clear;
    logic        in_ready, cs, we, fm, overflow;
    logic [31:0] addressin;
    logic [31:0] d0, d1, d2, d3, d4, d5, d6;
    logic [7:0]  contact_count;

    contact_pack_writer #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RAM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .clear(clear), .cs(cs), .we(we), .addressin(addressin),
        .datain0(d0), .datain1(d1), .datain2(d2), .datain3(d3),
        .datain4(d4), .datain5(d5), .datain6(d6),
        .fm(fm), .contact_count(contact_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_xfer_cyc = 0;
    bit run = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Reference model: records counted, words queued, base derived as 7*records.
    logic [31:0]       m_words[$];
    logic [6:0][31:0]  m_data;
    logic [31:0]       m_addr;
    int                m_rec;
    bit                m_wr, m_full, m_ovf;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_words.delete();
            m_data = '0;
            m_addr = 0;
            m_rec  = 0;
            m_wr   = 0;
            m_full = 0;
            m_ovf  = 0;
        end else if (m_wr) begin
            m_wr = 0;
            m_rec++;
            if (clear) begin
                m_rec = 0;
                m_ovf = 0;
            end else if (7 * m_rec + 7 > DEPTH) begin
                m_full = 1;
            end
        end else if (m_full) begin
            if (clear) begin
                m_full = 0;
                m_rec  = 0;
                m_ovf  = 0;
            end else if (in_valid) begin
                m_ovf = 1;
            end
        end else if (clear) begin
            m_words.delete();
            m_rec = 0;
            m_ovf = 0;
        end else if (in_valid) begin
            m_data[m_words.size()] = in_data;
            m_words.push_back(in_data);
            if (m_words.size() == 7) begin
                m_addr = 7 * m_rec;
                m_words.delete();
                m_wr = 1;
            end
        end
    end

    typedef struct packed {
        logic [31:0]      addr;
        logic [6:0][31:0] d;
        logic [31:0]      c;
    } wr_t;
    wr_t wlog[$];

    always @(negedge clk) begin
        if (!rst && run) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, !m_wr && !m_full});
            chk("cs", {31'd0, cs}, {31'd0, m_wr});
            chk("we", {31'd0, we}, {31'd0, m_wr});
            chk("fm", {31'd0, fm}, {31'd0, m_full});
            chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
            chk("contact_count", {24'd0, contact_count}, 32'(m_rec));
            if (m_wr) chk("addressin", addressin, m_addr);
            chk("datain0", d0, m_data[0]);
            chk("datain1", d1, m_data[1]);
            chk("datain2", d2, m_data[2]);
            chk("datain3", d3, m_data[3]);
            chk("datain4", d4, m_data[4]);
            chk("datain5", d5, m_data[5]);
            chk("datain6", d6, m_data[6]);
            if (cs) wlog.push_back('{addressin, {d6, d5, d4, d3, d2, d1, d0}, 32'(cyc)});
        end
    end

    task automatic push(input logic [31:0] w);
        int n = 0;
        in_valid = 1'b1;
        in_data  = w;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 40) begin
                chk("push_timeout", 32'd1, 32'd0);
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        last_xfer_cyc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; clear = 1'b0;
        do_reset();
        run = 1;
        idle(1);
        chk("reset_count", {24'd0, contact_count}, 32'd0);
        chk("reset_ready", {31'd0, in_ready}, 32'd1);

        // Single record
        wlog.delete();
        for (int i = 0; i < 7; i++) push(32'h10 + 32'(i));
        idle(2);
        chk("single_nwrites", 32'(wlog.size()), 32'd1);
        if (wlog.size() > 0) begin
            chk("single_addr", wlog[0].addr, 32'd0);
            chk("single_d0", wlog[0].d[0], 32'h10);
            chk("single_d6", wlog[0].d[6], 32'h16);
        end
        chk("single_count", {24'd0, contact_count}, 32'd1);
        chk("single_fm", {31'd0, fm}, 32'd0);

        // Fill
        do_reset();
        wlog.delete();
        for (int i = 0; i < 28; i++) push(32'h100 + 32'(i));
        idle(3);
        chk("fill_nwrites", 32'(wlog.size()), 32'd4);
        for (int i = 0; i < 4 && i < wlog.size(); i++) begin
            chk("fill_addr", wlog[i].addr, 32'(7 * i));
            if (i > 0) chk("fill_spacing", wlog[i].c - wlog[i-1].c, 32'd8);
        end
        chk("fill_count", {24'd0, contact_count}, 32'd4);
        chk("fill_fm", {31'd0, fm}, 32'd1);
        chk("fill_ready", {31'd0, in_ready}, 32'd0);

        // Overflow and recovery
        in_valid = 1'b1; in_data = 32'hDEAD;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        chk("ovf_nowrites", 32'(wlog.size()), 32'd4);
        pulse_clear();
        chk("clr_fm", {31'd0, fm}, 32'd0);
        chk("clr_ovf", {31'd0, overflow}, 32'd0);
        chk("clr_count", {24'd0, contact_count}, 32'd0);
        wlog.delete();
        for (int i = 0; i < 7; i++) push(32'h50 + 32'(i));
        idle(2);
        chk("recov_nwrites", 32'(wlog.size()), 32'd1);
        if (wlog.size() > 0) chk("recov_addr", wlog[0].addr, 32'd0);

        // Partial discard
        wlog.delete();
        for (int i = 0; i < 4; i++) push(32'h90 + 32'(i));
        pulse_clear();
        for (int i = 0; i < 7; i++) push(32'hA0 + 32'(i));
        idle(2);
        chk("partial_nwrites", 32'(wlog.size()), 32'd1);
        if (wlog.size() > 0) begin
            chk("partial_addr", wlog[0].addr, 32'd0);
            chk("partial_d0", wlog[0].d[0], 32'hA0);
            chk("partial_d6", wlog[0].d[6], 32'hA6);
        end

        // Bubbles
        wlog.delete();
        for (int i = 0; i < 7; i++) begin
            push(32'hB0 + 32'(i));
            if (i < 6) idle(1);
        end
        idle(2);
        chk("bubble_nwrites", 32'(wlog.size()), 32'd1);
        if (wlog.size() > 0) begin
            chk("bubble_addr", wlog[0].addr, 32'd7);
            for (int i = 0; i < 7; i++) chk("bubble_order", wlog[0].d[i], 32'hB0 + 32'(i));
            chk("bubble_latency", wlog[0].c, 32'(last_xfer_cyc));
        end

        // Async reset mid-record
        for (int i = 0; i < 3; i++) push(32'h30 + 32'(i));
        #2;
        rst = 1'b1;
        #1;
        chk("arst_cs", {31'd0, cs}, 32'd0);
        chk("arst_we", {31'd0, we}, 32'd0);
        chk("arst_addr", addressin, 32'd0);
        chk("arst_d0", d0, 32'd0);
        chk("arst_d2", d2, 32'd0);
        chk("arst_fm", {31'd0, fm}, 32'd0);
        chk("arst_count", {24'd0, contact_count}, 32'd0);
        chk("arst_ovf", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        wlog.delete();
        for (int i = 0; i < 7; i++) push(32'hC0 + 32'(i));
        idle(2);
        chk("arst_nwrites", 32'(wlog.size()), 32'd1);
        if (wlog.size() > 0) begin
            chk("arst_waddr", wlog[0].addr, 32'd0);
            chk("arst_wd0", wlog[0].d[0], 32'hC0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
